// File: rtl/jtdd_video_pkg.sv
// Default video timing shared by the colour mixer and renderers.
// Counts are 9-bit unsigned; every constant must stay below 512.
package jtdd_video_pkg;

  typedef logic [8:0] vcnt_t;

  localparam int H_TOTAL  = 384;
  localparam int H_VIS    = 256;
  localparam int HS_START = 296;
  localparam int HS_END   = 328;

  localparam int V_TOTAL  = 272;
  localparam int V_START  = 8;
  localparam int V_END    = 248;
  localparam int VS_START = 256;
  localparam int VS_END   = 259;

endpackage

// File: rtl/jtdd_vtimer_cnt.sv
// Wrap counter 0..TOTAL-1 with increment enable, terminal count (tc)
// and a registered [WIN_START, WIN_END) window flag built from nxt.
module jtdd_vtimer_cnt #(
  parameter int W         = 9,
  parameter int TOTAL     = 384,
  parameter int WIN_START = 0,
  parameter int WIN_END   = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic [W-1:0] nxt,
  output logic         tc,
  output logic         win
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);
  localparam logic [W-1:0] WS   = W'(WIN_START);
  localparam logic [W-1:0] WE   = W'(WIN_END);
  localparam logic WIN_RST = (WIN_START == 0) && (WIN_END > 0);

  logic [W-1:0] cnt_q, cnt_d;
  logic         win_q, win_d;

  assign tc = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (inc) begin
      cnt_d = tc ? '0 : cnt_q + 1'b1;
    end
    win_d = (cnt_d >= WS) && (cnt_d < WE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      win_q <= WIN_RST;
    end else begin
      cnt_q <= cnt_d;
      win_q <= win_d;
    end
  end

  assign cnt = cnt_q;
  assign nxt = cnt_d;
  assign win = win_q;

endmodule

// File: rtl/jtdd_vtimer.sv
// Video timing: pixel/line counts, blanking, syncs, vint/lint strobes.
// Ports: clk, rst (async high), pxl_cen in; hdump/vdump/vrender,
// hblank/vblank, hs/vs, vint/lint out. JTDD_FLIP_EN adds input flip.
module jtdd_vtimer
  import jtdd_video_pkg::*;
#(
  parameter int H_TOTAL  = jtdd_video_pkg::H_TOTAL,
  parameter int H_VIS    = jtdd_video_pkg::H_VIS,
  parameter int HS_START = jtdd_video_pkg::HS_START,
  parameter int HS_END   = jtdd_video_pkg::HS_END,
  parameter int V_TOTAL  = jtdd_video_pkg::V_TOTAL,
  parameter int V_START  = jtdd_video_pkg::V_START,
  parameter int V_END    = jtdd_video_pkg::V_END,
  parameter int VS_START = jtdd_video_pkg::VS_START,
  parameter int VS_END   = jtdd_video_pkg::VS_END
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl_cen,
`ifdef JTDD_FLIP_EN
  input  logic       flip,
`endif
  output logic [8:0] hdump,
  output logic [8:0] vdump,
  output logic [8:0] vrender,
  output logic       hblank,
  output logic       vblank,
  output logic       hs,
  output logic       vs,
  output logic       vint,
  output logic       lint
);

  localparam vcnt_t HV  = vcnt_t'(H_VIS);
  localparam vcnt_t VST = vcnt_t'(V_START);
  localparam vcnt_t VE  = vcnt_t'(V_END);
  localparam vcnt_t VL  = vcnt_t'(V_TOTAL - 1);

  vcnt_t h_cnt, h_nxt, v_cnt, v_nxt;
  logic  h_tc, v_tc_unused, h_wrap;
  logic  hs_w, vs_w;

  assign h_wrap = pxl_cen & h_tc;

  jtdd_vtimer_cnt #(
    .W(9), .TOTAL(H_TOTAL),
    .WIN_START(HS_START), .WIN_END(HS_END)
  ) u_hcnt (
    .clk (clk),
    .rst (rst),
    .inc (pxl_cen),
    .cnt (h_cnt),
    .nxt (h_nxt),
    .tc  (h_tc),
    .win (hs_w)
  );

  jtdd_vtimer_cnt #(
    .W(9), .TOTAL(V_TOTAL),
    .WIN_START(VS_START), .WIN_END(VS_END)
  ) u_vcnt (
    .clk (clk),
    .rst (rst),
    .inc (h_wrap),
    .cnt (v_cnt),
    .nxt (v_nxt),
    .tc  (v_tc_unused),
    .win (vs_w)
  );

  vcnt_t vrender_q, vrender_d;
  logic  hblank_q, hblank_d;
  logic  vblank_q, vblank_d;
  logic  vint_q, vint_d;
  logic  lint_q, lint_d;

  // Flags come from the next counts so they register alongside them.
  always_comb begin
    hblank_d  = (h_nxt >= HV);
    vblank_d  = (v_nxt < VST) || (v_nxt >= VE);
    vrender_d = (v_nxt == VL) ? '0 : v_nxt + 1'b1;
    vint_d    = h_wrap && (v_nxt == VE);
    lint_d    = h_wrap && (v_nxt[3:0] == 4'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vrender_q <= 9'd1;
      hblank_q  <= 1'b0;
      vblank_q  <= 1'b1;
      vint_q    <= 1'b0;
      lint_q    <= 1'b0;
    end else begin
      vrender_q <= vrender_d;
      hblank_q  <= hblank_d;
      vblank_q  <= vblank_d;
      vint_q    <= vint_d;
      lint_q    <= lint_d;
    end
  end

  assign hblank = hblank_q;
  assign vblank = vblank_q;
  assign hs     = hs_w;
  assign vs     = vs_w;
  assign vint   = vint_q;
  assign lint   = lint_q;

`ifdef JTDD_FLIP_EN
  assign hdump   = (flip && !hblank_q) ?
                   {h_cnt[8], ~h_cnt[7:0]} : h_cnt;
  assign vdump   = flip ? {v_cnt[8], ~v_cnt[7:0]} : v_cnt;
  assign vrender = flip ?
                   {vrender_q[8], ~vrender_q[7:0]} : vrender_q;
`else
  assign hdump   = h_cnt;
  assign vdump   = v_cnt;
  assign vrender = vrender_q;
`endif

endmodule

// File: tb/tb_jtdd_vtimer.sv
// Random pxl_cen bench for jtdd_vtimer: default and compact timing
// instances checked every clock against a raster-position model.
module tb_jtdd_vtimer;

  typedef struct packed {
    int ht, hv, hss, hse, vt, vst, ve, vss, vse;
  } tim_t;

  localparam tim_t T_B = '{384, 256, 296, 328, 272, 8, 248, 256, 259};
  localparam tim_t T_S = '{40, 24, 28, 32, 40, 3, 34, 35, 37};

  logic clk = 1'b0;
  logic rst;
  logic pxl_cen;
`ifdef JTDD_FLIP_EN
  logic flip = 1'b0;
`endif

  logic [8:0] hd_b, vd_b, vr_b, hd_s, vd_s, vr_s;
  logic hb_b, vb_b, hs_b, vs_b, vi_o_b, li_o_b;
  logic hb_s, vb_s, hs_s, vs_s, vi_o_s, li_o_s;

  always #5 clk = ~clk;

  jtdd_vtimer dut_b (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen),
`ifdef JTDD_FLIP_EN
    .flip(flip),
`endif
    .hdump(hd_b), .vdump(vd_b), .vrender(vr_b),
    .hblank(hb_b), .vblank(vb_b), .hs(hs_b), .vs(vs_b),
    .vint(vi_o_b), .lint(li_o_b)
  );

  jtdd_vtimer #(
    .H_TOTAL(40), .H_VIS(24), .HS_START(28), .HS_END(32),
    .V_TOTAL(40), .V_START(3), .V_END(34),
    .VS_START(35), .VS_END(37)
  ) dut_s (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen),
`ifdef JTDD_FLIP_EN
    .flip(flip),
`endif
    .hdump(hd_s), .vdump(vd_s), .vrender(vr_s),
    .hblank(hb_s), .vblank(vb_s), .hs(hs_s), .vs(vs_s),
    .vint(vi_o_s), .lint(li_o_s)
  );

  int checks = 0;
  int errors = 0;
  int p_b, p_s;
  bit vi_b, li_b, vi_s, li_s;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // p is the pixel index within the frame; strobes mark arrival at
  // the first pixel of a line on an enabled edge.
  task automatic model_step(input tim_t t, input bit r, input bit cen,
                            inout int p, output bit vi, output bit li);
    int v;
    vi = 1'b0;
    li = 1'b0;
    if (r) begin
      p = 0;
    end else if (cen) begin
      p = (p + 1) % (t.ht * t.vt);
      if (p % t.ht == 0) begin
        v  = p / t.ht;
        vi = (v == t.ve);
        li = (v % 16 == 0);
      end
    end
  endtask

  task automatic check_all(input string n, input tim_t t, input int p,
                           input bit vi, input bit li,
                           input logic [8:0] hd, input logic [8:0] vd,
                           input logic [8:0] vr,
                           input logic hb, input logic vb,
                           input logic hsy, input logic vsy,
                           input logic vio, input logic lio);
    int h, v;
    h = p % t.ht;
    v = p / t.ht;
    chk({n, "_hdump"}, int'(hd), h);
    chk({n, "_vdump"}, int'(vd), v);
    chk({n, "_vrender"}, int'(vr), (v + 1) % t.vt);
    chk({n, "_hblank"}, int'(hb), int'(h >= t.hv));
    chk({n, "_vblank"}, int'(vb), int'(v < t.vst || v >= t.ve));
    chk({n, "_hs"}, int'(hsy), int'(h >= t.hss && h < t.hse));
    chk({n, "_vs"}, int'(vsy), int'(v >= t.vss && v < t.vse));
    chk({n, "_vint"}, int'(vio), int'(vi));
    chk({n, "_lint"}, int'(lio), int'(li));
  endtask

  task automatic check_both();
    check_all("B", T_B, p_b, vi_b, li_b, hd_b, vd_b, vr_b,
              hb_b, vb_b, hs_b, vs_b, vi_o_b, li_o_b);
    check_all("S", T_S, p_s, vi_s, li_s, hd_s, vd_s, vr_s,
              hb_s, vb_s, hs_s, vs_s, vi_o_s, li_o_s);
  endtask

  task automatic step(input bit cen);
    bit r;
    pxl_cen = cen;
    r = rst;
    @(posedge clk);
    model_step(T_B, r, cen, p_b, vi_b, li_b);
    model_step(T_S, r, cen, p_s, vi_s, li_s);
    @(negedge clk);
    check_both();
  endtask

  int n_vint_s, n_lint_s;
  int guard;

  initial begin
    rst     = 1'b1;
    pxl_cen = 1'b0;
    p_b = 0; p_s = 0;
    vi_b = 0; li_b = 0; vi_s = 0; li_s = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_both();
    rst = 1'b0;

    for (int i = 0; i < 384 * 4 + 8; i++) step(i % 4 == 3);
    chk("line_wrap_vdump", int'(vd_b), 1);

    for (int i = 0; i < 6000; i++) step($urandom_range(0, 3) != 0);

    n_vint_s = 0;
    n_lint_s = 0;
    for (int i = 0; i < 1600; i++) begin
      step(1'b1);
      n_vint_s += int'(vi_o_s);
      n_lint_s += int'(li_o_s);
    end
    chk("frame_vint_cnt", n_vint_s, 1);
    chk("frame_lint_cnt", n_lint_s, 3);

    guard = 0;
    while (p_b != 100 * 384 + 200 && guard < 60000) begin
      step(1'b1);
      guard++;
    end
    chk("reach_v100_h200", int'(p_b == 100 * 384 + 200), 1);

    rst = 1'b1;
    #1;
    p_b = 0; p_s = 0;
    vi_b = 0; li_b = 0; vi_s = 0; li_s = 0;
    check_both();
    repeat (3) step(1'b1);
    rst = 1'b0;
    for (int i = 0; i < 300; i++) step(1'b1);

    for (int i = 0; i < 1000; i++) step(1'b0);

    for (int i = 0; i < 2000; i++) step($urandom_range(0, 1) == 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
